// File: rtl/cacheline_adaptor_pkg.sv
// Shared sizing and FSM state type for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits a cache line writeback into ascending memory beats and assembles
// memory beats into a cache line fill; one transaction at a time.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = cacheline_adaptor_pkg::LINE_W,
  parameter int unsigned BURST_W = cacheline_adaptor_pkg::BURST_W,
  parameter int unsigned BEATS   = LINE_W / BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [31:0]        pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  import cacheline_adaptor_pkg::*;

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        addr_q;
  // Holds the writeback line during WRITE and the partial fill during READ.
  logic [BURST_W-1:0] line_q [BEATS];
  logic [LINE_W-1:0]  fill_line;
  logic               last_beat;

  assign last_beat   = mem_resp && (count_q == LAST);
  assign mem_address = addr_q & 32'hFFFF_FFE0;
  assign mem_wdata   = line_q[count_q];

  // The completed fill combines the buffered beats with the one arriving now,
  // so pmem_rdata only ever changes to a whole line.
  always_comb begin
    fill_line = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      fill_line[i*BURST_W +: BURST_W] = (i == BEATS - 1) ? mem_rdata : line_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (pmem_write)     state_d = WRITE;
        else if (pmem_read) state_d = READ;
      end
      READ: begin
        mem_read = 1'b1;
        if (last_beat) state_d = DONE;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      addr_q     <= '0;
      pmem_rdata <= '0;
      for (int unsigned i = 0; i < BEATS; i++) line_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pmem_write) begin
            addr_q  <= pmem_address;
            count_q <= '0;
            for (int unsigned i = 0; i < BEATS; i++) line_q[i] <= pmem_wdata[i*BURST_W +: BURST_W];
          end else if (pmem_read) begin
            addr_q  <= pmem_address;
            count_q <= '0;
          end
        end
        READ: begin
          if (mem_resp) begin
            line_q[count_q] <= mem_rdata;
            count_q         <= last_beat ? '0 : count_q + CNT_W'(1);
            if (last_beat) pmem_rdata <= fill_line;
          end
        end
        WRITE: begin
          if (mem_resp) count_q <= last_beat ? '0 : count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: the bench plays both the cache and the memory.
module tb_cacheline_adaptor;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pmem_read, pmem_write;
  logic [31:0]        pmem_address;
  logic [LINE_W-1:0]  pmem_wdata, pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        mem_address;
  logic               mem_read, mem_write;
  logic [BURST_W-1:0] mem_wdata, mem_rdata;
  logic               mem_resp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [LINE_W-1:0] last_fill;

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Request at cycle 0; the cycle after the BEATS-th accepted beat is the response.
  function automatic int expected_resp_cycle(input logic [63:0] mask);
    int seen = 0;
    for (int c = 1; c < 64; c++) begin
      if (mask[c]) seen++;
      if (seen == BEATS) return c + 1;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand_mask();
    logic [63:0] m = '0;
    int c = 1;
    for (int b = 0; b < BEATS; b++) begin
      c += $urandom_range(0, 3);
      m[c] = 1'b1;
      c++;
    end
    return m;
  endfunction

  // Runs one transaction from a negedge in IDLE; returns at the negedge after DONE.
  task automatic drive_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] rline,
                           input logic [63:0] mask,
                           output logic [BURST_W-1:0] wb [8], output int nwb,
                           output int resp_cycle, output bit saw_rd, output bit saw_wr,
                           output bit saw_both, output logic [31:0] addr_first,
                           output bit addr_changed, output bit rdata_moved, output bit resp_long);
    logic [LINE_W-1:0] rdata0;
    int  nrb = 0;
    bit  first = 1'b1;
    nwb = 0; resp_cycle = -1; saw_rd = 0; saw_wr = 0; saw_both = 0;
    addr_first = '0; addr_changed = 0; rdata_moved = 0; resp_long = 0;
    for (int i = 0; i < 8; i++) wb[i] = '0;
    pmem_write = wr; pmem_read = rd; pmem_address = addr; pmem_wdata = wline;
    mem_resp = 1'b0; mem_rdata = {$urandom, $urandom};
    rdata0 = pmem_rdata;
    for (int c = 1; c < 64 && resp_cycle < 0; c++) begin
      @(negedge clk);
      if (pmem_resp) begin
        resp_cycle = c; pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
      end else begin
        if (pmem_rdata !== rdata0) rdata_moved = 1;
        if (mem_read && mem_write) saw_both = 1;
        if (mem_read) saw_rd = 1;
        if (mem_write) saw_wr = 1;
        if (mem_read || mem_write) begin
          if (first) begin addr_first = mem_address; first = 0; end
          else if (mem_address !== addr_first) addr_changed = 1;
        end
        mem_resp  = mask[c];
        mem_rdata = {$urandom, $urandom};
        if (mem_resp && mem_write && nwb < 8) begin wb[nwb] = mem_wdata; nwb++; end
        if (mem_resp && mem_read && nrb < BEATS) begin mem_rdata = rline[nrb*BURST_W +: BURST_W]; nrb++; end
      end
    end
    pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    resp_long = (pmem_resp !== 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {mem_read, mem_write, pmem_resp}); end
    n_cmp++; if (pmem_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", pmem_rdata); end
    n_cmp++; if (mem_address !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_address); end
    reset_n = 1'b1;
    last_fill = '0;
    @(negedge clk);
  endtask

  task automatic test_read_nogap();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0;
    logic [LINE_W-1:0] line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    drive_txn(0, 1, 32'h0000_1234, '0, line, 64'h1E, wb, nwb, rc, srd, swr, sboth, a0, achg, rmov, rlong);
    last_fill = line;
    n_cmp++; if (a0 !== 32'h0000_1220) begin n_bad++; $display("FAIL rd_addr: got %h want 00001220", a0); end
    n_cmp++; if (achg !== 0) begin n_bad++; $display("FAIL rd_addr_stable: got %0d want 0", achg); end
    n_cmp++; if (rc !== BEATS + 1) begin n_bad++; $display("FAIL rd_latency: got %0d want %0d", rc, BEATS + 1); end
    n_cmp++; if (pmem_rdata !== line) begin n_bad++; $display("FAIL rd_line: got %h want %h", pmem_rdata, line); end
    n_cmp++; if ({srd, swr} !== 2'b10) begin n_bad++; $display("FAIL rd_strobes: got %b want 10", {srd, swr}); end
    n_cmp++; if (rmov !== 0) begin n_bad++; $display("FAIL rd_partial: got %0d want 0", rmov); end
    n_cmp++; if (rlong !== 0) begin n_bad++; $display("FAIL rd_resp_width: got %0d want 0", rlong); end
  endtask

  task automatic test_write_gaps();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0;
    logic [LINE_W-1:0] line = rand_line();
    logic [63:0] mask = (64'd1 << 1) | (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 7);
    drive_txn(1, 0, 32'hABCD_EF7F, line, '0, mask, wb, nwb, rc, srd, swr, sboth, a0, achg, rmov, rlong);
    n_cmp++; if (nwb !== BEATS) begin n_bad++; $display("FAIL wr_beats: got %0d want %0d", nwb, BEATS); end
    for (int i = 0; i < BEATS; i++) begin
      n_cmp++; if (wb[i] !== line[i*BURST_W +: BURST_W]) begin n_bad++; $display("FAIL wr_beat%0d: got %h want %h", i, wb[i], line[i*BURST_W +: BURST_W]); end
    end
    n_cmp++; if (rc !== 8) begin n_bad++; $display("FAIL wr_latency: got %0d want 8", rc); end
    n_cmp++; if (a0 !== 32'hABCD_EF60) begin n_bad++; $display("FAIL wr_addr: got %h want abcdef60", a0); end
    n_cmp++; if (pmem_rdata !== last_fill) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want %h", pmem_rdata, last_fill); end
  endtask

  task automatic test_simultaneous();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0;
    logic [LINE_W-1:0] line = rand_line();
    drive_txn(1, 1, 32'h0000_4000, line, rand_line(), 64'h1E, wb, nwb, rc, srd, swr, sboth, a0, achg, rmov, rlong);
    n_cmp++; if ({srd, swr, sboth} !== 3'b010) begin n_bad++; $display("FAIL both_priority: got %b want 010", {srd, swr, sboth}); end
    n_cmp++; if (wb[0] !== line[BURST_W-1:0]) begin n_bad++; $display("FAIL both_beat0: got %h want %h", wb[0], line[BURST_W-1:0]); end
    n_cmp++; if (pmem_rdata !== last_fill) begin n_bad++; $display("FAIL both_rdata: got %h want %h", pmem_rdata, last_fill); end
  endtask

  task automatic test_back_to_back();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc1, rc2; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0;
    logic [LINE_W-1:0] wline = rand_line();
    logic [LINE_W-1:0] rline = rand_line();
    drive_txn(1, 0, 32'h1000_0040, wline, '0, rand_mask(), wb, nwb, rc1, srd, swr, sboth, a0, achg, rmov, rlong);
    n_cmp++; if (rc1 < 0) begin n_bad++; $display("FAIL b2b_wr_resp: got %0d want response", rc1); end
    n_cmp++; if (wb[BEATS-1] !== wline[LINE_W-1 -: BURST_W]) begin n_bad++; $display("FAIL b2b_wr_last: got %h want %h", wb[BEATS-1], wline[LINE_W-1 -: BURST_W]); end
    drive_txn(0, 1, 32'h2000_0080, '0, rline, rand_mask(), wb, nwb, rc2, srd, swr, sboth, a0, achg, rmov, rlong);
    last_fill = rline;
    n_cmp++; if (rc2 < 0) begin n_bad++; $display("FAIL b2b_rd_resp: got %0d want response", rc2); end
    n_cmp++; if (pmem_rdata !== rline) begin n_bad++; $display("FAIL b2b_fill: got %h want %h", pmem_rdata, rline); end
    n_cmp++; if (a0 !== 32'h2000_0080) begin n_bad++; $display("FAIL b2b_rd_addr: got %h want 20000080", a0); end
  endtask

  task automatic test_reset_midburst();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0;
    logic [LINE_W-1:0] line = rand_line();
    logic [63:0] mask = rand_mask();
    pmem_read = 1'b1; pmem_address = 32'h0000_9ABC; mem_resp = 1'b0;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_resp = 1'b0;
    #2 reset_n = 1'b0; pmem_read = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin n_bad++; $display("FAIL abort_ctrl: got %b want 000", {mem_read, mem_write, pmem_resp}); end
    n_cmp++; if (pmem_rdata !== '0) begin n_bad++; $display("FAIL abort_rdata: got %h want 0", pmem_rdata); end
    n_cmp++; if (mem_address !== 32'h0) begin n_bad++; $display("FAIL abort_addr: got %h want 0", mem_address); end
    last_fill = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive_txn(0, 1, 32'h0000_5560, '0, line, mask, wb, nwb, rc, srd, swr, sboth, a0, achg, rmov, rlong);
    last_fill = line;
    n_cmp++; if (pmem_rdata !== line) begin n_bad++; $display("FAIL abort_refill: got %h want %h", pmem_rdata, line); end
    n_cmp++; if (rc !== expected_resp_cycle(mask)) begin n_bad++; $display("FAIL abort_latency: got %0d want %0d", rc, expected_resp_cycle(mask)); end
  endtask

  task automatic test_idle_resp();
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      n_cmp++; if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin n_bad++; $display("FAIL idle_ctrl: got %b want 000", {mem_read, mem_write, pmem_resp}); end
      n_cmp++; if (pmem_rdata !== last_fill) begin n_bad++; $display("FAIL idle_rdata: got %h want %h", pmem_rdata, last_fill); end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_random();
    logic [BURST_W-1:0] wb [8];
    int nwb, rc, kind; bit srd, swr, sboth, achg, rmov, rlong; logic [31:0] a0, addr;
    logic [LINE_W-1:0] wline, rline; logic [63:0] mask;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom; wline = rand_line(); rline = rand_line(); mask = rand_mask();
      drive_txn(kind != 0, kind != 1, addr, wline, rline, mask, wb, nwb, rc, srd, swr, sboth, a0, achg, rmov, rlong);
      if (kind == 0) last_fill = rline;
      n_cmp++; if (rc !== expected_resp_cycle(mask)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, rc, expected_resp_cycle(mask)); end
      n_cmp++; if ({a0, achg, sboth, rmov, rlong} !== {addr & 32'hFFFF_FFE0, 4'b0000}) begin n_bad++; $display("FAIL rnd%0d_addr_flags: got %h/%b want %h/0000", t, a0, {achg, sboth, rmov, rlong}, addr & 32'hFFFF_FFE0); end
      n_cmp++; if (pmem_rdata !== last_fill) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", t, pmem_rdata, last_fill); end
      if (kind != 0) begin
        n_cmp++; if ({wb[3], wb[2], wb[1], wb[0]} !== wline || nwb !== BEATS) begin n_bad++; $display("FAIL rnd%0d_wbeats: got %h (%0d beats) want %h", t, {wb[3], wb[2], wb[1], wb[0]}, nwb, wline); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_nogap();
    test_write_gaps();
    test_simultaneous();
    test_back_to_back();
    test_reset_midburst();
    test_idle_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits.
REQ-003 SHALL have parameter BEATS, default LINE_W/BURST_W = 4, beats per line.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pmem_read, input, 1, cache requests a line fill.
REQ-007 SHALL have port pmem_write, input, 1, cache requests a line writeback.
REQ-008 SHALL have port pmem_address, input, 32, line byte address from the cache.
REQ-009 SHALL have port pmem_wdata, input, LINE_W, line to write back.
REQ-010 SHALL have port pmem_rdata, output, LINE_W, assembled fill line.
REQ-011 SHALL have port pmem_resp, output, 1, transaction-complete pulse to the cache.
REQ-012 SHALL have port mem_address, output, 32, burst address to memory.
REQ-013 SHALL have port mem_read, output, 1, burst read request.
REQ-014 SHALL have port mem_write, output, 1, burst write request.
REQ-015 SHALL have port mem_wdata, output, BURST_W, current write beat.
REQ-016 SHALL have port mem_rdata, input, BURST_W, current read beat.
REQ-017 SHALL have port mem_resp, input, 1, memory accepted/delivered one beat this cycle.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 IDLE: pmem_write=1 -> latch pmem_address and pmem_wdata, beat count 0, go to WRITE; write has priority over a simultaneous read.
REQ-020 IDLE: pmem_read=1 with pmem_write=0 -> latch pmem_address, beat count 0, go to READ.
REQ-021 mem_address SHALL equal the latched address with bits [4:0] cleared and SHALL hold stable for the whole transaction.
REQ-022 READ: mem_read=1; each cycle with mem_resp=1, store mem_rdata into line beat[count] and increment count; mem_resp=0 cycles (gaps) hold state.
REQ-023 WRITE: mem_write=1, mem_wdata=latched line beat[count]; each cycle with mem_resp=1 increments count.
REQ-024 Beat order SHALL be ascending: beat 0 = bits [BURST_W-1:0] first.
REQ-025 When mem_resp=1 with count=BEATS-1, the FSM SHALL go to DONE and count SHALL wrap to 0.
REQ-026 DONE: pmem_resp=1 for exactly one cycle, mem_read=mem_write=0; next state IDLE unconditionally.
REQ-027 Minimum latency, request to pmem_resp: BEATS+2 cycles (1 latch cycle, BEATS beat cycles, 1 DONE cycle).
REQ-028 pmem_rdata SHALL hold the last fully assembled line until the next READ completes and never expose a partial line.
REQ-029 mem_resp SHALL be ignored in IDLE and DONE.
REQ-030 A request still asserted in the cycle after DONE SHALL start a new transaction (the cache deasserts after pmem_resp).
REQ-031 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, count=0, mem_read=mem_write=pmem_resp=0, pmem_rdata=0, latched address/data=0, including mid-burst; the aborted transaction is dropped.

Structure
REQ-033 A shared package SHALL hold LINE_W, BURST_W, BEATS and the FSM state enum.
REQ-034 SHALL be a single module with no sub-modules; the line buffer is a BEATS x BURST_W register array.

Verification
REQ-035 Read, no gaps: pmem_read, address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_address=0x0000_1220, pmem_resp one cycle after beat 4, pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-036 Write with gaps: pmem_write, line {D3,D2,D1,D0}, mem_resp on cycles 1,3,4,7 -> mem_wdata D0,D1,D2,D3 in order, held across gaps; pmem_resp only after the 4th beat.
REQ-037 Simultaneous pmem_read=pmem_write=1 in IDLE -> WRITE taken, mem_write=1, mem_read=0.
REQ-038 Writeback immediately followed by fill (evict then replace): both complete, pmem_resp pulses twice, pmem_rdata reflects the fill only.
REQ-039 reset_n low after beat 2 of a read -> outputs zero asynchronously; after release a new read completes normally with fresh data.
REQ-040 mem_resp pulsed in IDLE -> no state change, pmem_rdata unchanged.
